alu_sched: RTL and testbench
============================

Name: alu_sched

Overview:
- Sequencer and arbiter that shares the single ALU (Arith/Logic/CMP/Shift units, unit chosen by ALU_FUN[3:2]) between two requesters.
- Accepts one command at a time through valid/ready handshakes and issues it to the ALU with a one-cycle enable pulse.
- Waits for the ALU result, with a watchdog, and returns the result with a requester ID on a valid/ready response channel.
- Sits between the control unit / register-file port masters and the ALU top.

Parameters:
- OPER_WIDTH, 16, width of operands and result.
- FUN_WIDTH, 4, width of function code. Bits [3:2] select the unit; bits [1:0] select the operation within the unit.
- TIMEOUT, 8, number of WAIT cycles without ALU_Out_Valid before an error response is returned (>=2).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- Req0_Valid  in  1  requester 0 command valid.
- Req0_Ready  out  1  requester 0 command accepted this cycle.
- Req0_A / Req0_B  in  OPER_WIDTH  requester 0 operands.
- Req0_Fun  in  FUN_WIDTH  requester 0 function code.
- Req1_Valid / Req1_Ready / Req1_A / Req1_B / Req1_Fun  same as above, for requester 1.
- ALU_A / ALU_B  out  OPER_WIDTH  operands to ALU, registered.
- ALU_FUN  out  FUN_WIDTH  function code to ALU, registered.
- ALU_Enable  out  1  one-cycle issue strobe, qualifies the unit decoder.
- ALU_Out  in  OPER_WIDTH  ALU result.
- ALU_Out_Valid  in  1  ALU result valid.
- Resp_Valid  out  1  response valid.
- Resp_Ready  in  1  response accepted.
- Resp_Data  out  OPER_WIDTH  captured result.
- Resp_ID  out  1  requester the response belongs to.
- Resp_Err  out  1  watchdog expired; Resp_Data is 0.
- Busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (RST low, asynchronous): state=IDLE; all outputs 0; watchdog count=0; last-grant pointer=1, so requester 0 wins the first tie.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Reqx_Ready is combinational: asserted only for the arbitration winner, and only in IDLE.
  - Round-robin: if exactly one Valid is high, that requester wins. If both are high, the requester not granted last wins.
  - On grant, capture A/B/Fun into ALU_A/ALU_B/ALU_FUN, capture the ID, update the pointer, go to ISSUE.
  - No Valid high: stay in IDLE.
- ISSUE: ALU_Enable=1 for exactly this cycle; clear the watchdog; go to WAIT. ALU_Out_Valid is ignored in ISSUE.
- WAIT:
  - ALU_Enable=0; ALU_A/B/FUN held stable.
  - If ALU_Out_Valid: Resp_Data<=ALU_Out, Resp_Err<=0, go to RESP.
  - Else increment the watchdog. When it reaches TIMEOUT-1 with no valid: Resp_Data<=0, Resp_Err<=1, go to RESP.
  - ALU_Out_Valid in that same final cycle takes priority over the timeout.
- RESP:
  - Resp_Valid=1; Resp_Data/Resp_ID/Resp_Err are held until Resp_Ready.
  - On Resp_Valid&&Resp_Ready: drop Resp_Valid next cycle and go to IDLE.
  - Backpressure is unbounded; no new command is accepted while in RESP.
- ALU_Out_Valid outside WAIT is ignored.
- Requester Valid may drop before grant without effect. Operands are sampled only at the handshake cycle.
- Latency (ALU result one cycle after enable):
  - grant at cycle T, ALU_Enable at T+1, capture at T+2, Resp_Valid at T+3.
  - Best throughput is one command per 4 cycles with Resp_Ready tied high (RESP->IDLE->grant).
- ALU_FUN is passed through unmodified; no width conversion.
- Reset mid-operation: the in-flight command is dropped with no response; the pointer returns to 1.

Decomposition:
- Package alu_sched_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP);
  - unit select constants ARITH=2'b00, LOGIC=2'b01, CMP=2'b10, SHIFT=2'b11;
  - default TIMEOUT.
- Sub-module rr_arb2: two-input round-robin arbiter. Inputs: request vector, last-grant pointer. Output: one-hot grant. Purely combinational; the pointer register lives in alu_sched.

Test Plan:
- Single request: Req0 valid, A=16'h0003, B=16'h0004, Fun=4'b0000.
  - Req0_Ready at T; ALU_Enable at T+1 with those values.
  - ALU returns 16'h0007 at T+2 -> Resp_Valid at T+3, Data=0007, ID=0, Err=0.
- Simultaneous requests after reset, held high:
  - grants alternate 0,1,0,1 across four commands;
  - Resp_ID sequence 0,1,0,1.
- Timeout: ALU_Out_Valid never asserted.
  - Resp_Valid with Err=1, Data=0 exactly TIMEOUT WAIT cycles after ISSUE.
  - Late valid at the final WAIT cycle -> Err=0.
- Backpressure: Resp_Ready low 5 cycles.
  - Resp_Data/ID held stable and Req1_Ready stays 0 despite Req1_Valid.
  - Req1 is granted the cycle after returning to IDLE.
- Spurious ALU_Out_Valid in IDLE/ISSUE/RESP: no state change, Resp_Data unchanged.
- Async reset asserted in WAIT:
  - all outputs 0 immediately, without waiting for a clock edge;
  - after release, with both requesters valid, requester 0 is granted first.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU sequencer/arbiter.
package alu_sched_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_t;

    // Unit select encoding carried in ALU_FUN[3:2]
    localparam logic [1:0] ARITH = 2'b00;
    localparam logic [1:0] LOGIC = 2'b01;
    localparam logic [1:0] CMP   = 2'b10;
    localparam logic [1:0] SHIFT = 2'b11;

    // Watchdog length in WAIT cycles
    localparam int DEFAULT_TIMEOUT = 8;

    // Unit field of a function code
    function automatic logic [1:0] unit_of(input logic [3:0] fun);
        return fun[3:2];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter, purely combinational.
// last = index of the requester granted most recently; on a tie the other one wins.
module rr_arb2
    import alu_sched_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // One-hot grant; a lone request always wins, a tie goes to the non-last requester
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_sched.sv
// Shares one ALU between two requesters: arbitrate, issue with a one-cycle
// enable, wait for the result under a watchdog, and return it on a
// valid/ready response channel tagged with the requester ID.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int OPER_WIDTH = 16,
    parameter int FUN_WIDTH  = 4,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  CLK,
    input  logic                  RST,

    input  logic                  Req0_Valid,
    output logic                  Req0_Ready,
    input  logic [OPER_WIDTH-1:0] Req0_A,
    input  logic [OPER_WIDTH-1:0] Req0_B,
    input  logic [FUN_WIDTH-1:0]  Req0_Fun,

    input  logic                  Req1_Valid,
    output logic                  Req1_Ready,
    input  logic [OPER_WIDTH-1:0] Req1_A,
    input  logic [OPER_WIDTH-1:0] Req1_B,
    input  logic [FUN_WIDTH-1:0]  Req1_Fun,

    output logic [OPER_WIDTH-1:0] ALU_A,
    output logic [OPER_WIDTH-1:0] ALU_B,
    output logic [FUN_WIDTH-1:0]  ALU_FUN,
    output logic                  ALU_Enable,
    input  logic [OPER_WIDTH-1:0] ALU_Out,
    input  logic                  ALU_Out_Valid,

    output logic                  Resp_Valid,
    input  logic                  Resp_Ready,
    output logic [OPER_WIDTH-1:0] Resp_Data,
    output logic                  Resp_ID,
    output logic                  Resp_Err,

    output logic                  Busy
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t          state;
    logic            last_gnt;   // requester granted most recently
    logic            cur_id;     // requester of the command in flight
    logic [WD_W-1:0] wdog;

    // Requesters gathered into indexable arrays so the grant selects by ID
    logic [1:0]                 req_vld;
    logic [1:0]                 gnt;
    logic                       gsel;
    logic [1:0][OPER_WIDTH-1:0] req_a;
    logic [1:0][OPER_WIDTH-1:0] req_b;
    logic [1:0][FUN_WIDTH-1:0]  req_fun;

    assign req_vld = {Req1_Valid, Req0_Valid};
    assign req_a   = {Req1_A, Req0_A};
    assign req_b   = {Req1_B, Req0_B};
    assign req_fun = {Req1_Fun, Req0_Fun};
    assign gsel    = gnt[1];

    rr_arb2 u_arb (
        .req  (req_vld),
        .last (last_gnt),
        .gnt  (gnt)
    );

    // Ready only for the winner, only in IDLE; held low while reset is asserted
    assign Req0_Ready = RST && (state == IDLE) && gnt[0];
    assign Req1_Ready = RST && (state == IDLE) && gnt[1];
    assign Busy       = (state != IDLE);

    // Sequencer: grant -> issue pulse -> wait with watchdog -> hold response
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            last_gnt   <= 1'b1;
            cur_id     <= 1'b0;
            wdog       <= '0;
            ALU_A      <= '0;
            ALU_B      <= '0;
            ALU_FUN    <= '0;
            ALU_Enable <= 1'b0;
            Resp_Valid <= 1'b0;
            Resp_Data  <= '0;
            Resp_ID    <= 1'b0;
            Resp_Err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt != 2'b00) begin
                        ALU_A      <= req_a[gsel];
                        ALU_B      <= req_b[gsel];
                        ALU_FUN    <= req_fun[gsel];
                        cur_id     <= gsel;
                        last_gnt   <= gsel;
                        ALU_Enable <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Result cannot arrive yet; any valid here is ignored
                    ALU_Enable <= 1'b0;
                    wdog       <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (ALU_Out_Valid) begin
                        // A result in the last watchdog cycle still counts
                        Resp_Data  <= ALU_Out;
                        Resp_Err   <= 1'b0;
                        Resp_ID    <= cur_id;
                        Resp_Valid <= 1'b1;
                        state      <= RESP;
                    end else if (wdog == WD_LAST) begin
                        Resp_Data  <= '0;
                        Resp_Err   <= 1'b1;
                        Resp_ID    <= cur_id;
                        Resp_Valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                RESP: begin
                    // Response fields stay put until the consumer takes them
                    if (Resp_Ready) begin
                        Resp_Valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: directed scenarios plus a randomized run,
// all compared against a transaction-level reference model.
module tb_alu_sched;

    localparam int W  = 16;
    localparam int FW = 4;
    localparam int TO = 8;

    logic          CLK;
    logic          RST;
    logic          Req0_Valid, Req1_Valid;
    logic          Req0_Ready, Req1_Ready;
    logic [W-1:0]  Req0_A, Req0_B, Req1_A, Req1_B;
    logic [FW-1:0] Req0_Fun, Req1_Fun;
    logic [W-1:0]  ALU_A, ALU_B, ALU_Out;
    logic [FW-1:0] ALU_FUN;
    logic          ALU_Enable, ALU_Out_Valid;
    logic          Resp_Valid, Resp_Ready;
    logic [W-1:0]  Resp_Data;
    logic          Resp_ID, Resp_Err, Busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // ALU stand-in controls: latency in cycles after enable (0 = never), spurious pulses
    int alu_lat = 1;
    bit spur_en = 0;

    alu_sched #(.OPER_WIDTH(W), .FUN_WIDTH(FW), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .Req0_Valid(Req0_Valid), .Req0_Ready(Req0_Ready), .Req0_A(Req0_A), .Req0_B(Req0_B), .Req0_Fun(Req0_Fun),
        .Req1_Valid(Req1_Valid), .Req1_Ready(Req1_Ready), .Req1_A(Req1_A), .Req1_B(Req1_B), .Req1_Fun(Req1_Fun),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_Enable(ALU_Enable),
        .ALU_Out(ALU_Out), .ALU_Out_Valid(ALU_Out_Valid),
        .Resp_Valid(Resp_Valid), .Resp_Ready(Resp_Ready), .Resp_Data(Resp_Data),
        .Resp_ID(Resp_ID), .Resp_Err(Resp_Err), .Busy(Busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Behavioural ALU used both to drive results and to predict them
    function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [FW-1:0] f);
        logic [W-1:0] r;
        case (f)
            4'h0: r = a + b;
            4'h1: r = a - b;
            4'h2: r = a * b;
            4'h3: r = a + 16'd1;
            4'h4: r = a & b;
            4'h5: r = a | b;
            4'h6: r = ~(a & b);
            4'h7: r = a ^ b;
            4'h8: r = (a == b) ? 16'd1 : 16'd0;
            4'h9: r = (a > b) ? 16'd1 : 16'd0;
            4'hA: r = (a < b) ? 16'd1 : 16'd0;
            4'hB: r = 16'd0;
            4'hC: r = a >> 1;
            4'hD: r = a << 1;
            4'hE: r = b >> 2;
            default: r = b << 2;
        endcase
        return r;
    endfunction

    // Round-robin rule: lone request wins, tie goes to the one not granted last
    function automatic int winner(input logic v0, input logic v1, input int last);
        if (v0 && v1) return (last == 1) ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // ALU stand-in: result 'alu_lat' cycles after the enable cycle; optional
    // spurious pulses, kept out of the result window so they never look like a result
    initial begin
        int k, due;
        bit pend, in_win;
        ALU_Out = '0; ALU_Out_Valid = 1'b0;
        pend = 0; k = 0; due = -1;
        forever begin
            @(posedge CLK); #1;
            if (ALU_Enable) begin
                pend = 1; k = cyc;
                due  = (alu_lat == 0) ? -1 : cyc + alu_lat;
            end
            if (pend && cyc > k + TO) pend = 0;
            in_win = pend && (cyc >= k + 1) && (cyc <= k + TO);
            if (pend && cyc == due) begin
                ALU_Out_Valid = 1'b1;
                ALU_Out = ref_alu(ALU_A, ALU_B, ALU_FUN);
            end else if (!in_win && spur_en && $urandom_range(0, 2) == 0) begin
                ALU_Out_Valid = 1'b1;
                ALU_Out = W'($urandom);
            end else begin
                ALU_Out_Valid = 1'b0;
                ALU_Out = W'($urandom);
            end
        end
    end

    // Reference model: one command in flight, tracked by grant cycle and
    // expected response; checks every output on every clock
    initial begin
        bit m_busy, exp_rv, exp_en;
        int m_last, m_gcyc, m_rcyc, m_id, w, c;
        logic [W-1:0]  m_a, m_b, m_rdata;
        logic [FW-1:0] m_fun;
        bit m_rerr;
        m_busy = 0; m_last = 1; m_gcyc = 0; m_rcyc = -1; m_id = 0;
        m_a = '0; m_b = '0; m_fun = '0; m_rdata = '0; m_rerr = 0;
        forever begin
            @(negedge CLK or negedge RST);
            if (!RST) begin
                m_busy = 0; m_last = 1; m_rcyc = -1;
            end else if (!CLK) begin
                c = cyc;
                exp_rv = m_busy && (m_rcyc >= 0) && (c >= m_rcyc);
                exp_en = m_busy && (c == m_gcyc + 1);
                chk("sb_busy", Busy, m_busy);
                chk("sb_resp_valid", Resp_Valid, exp_rv);
                if (exp_rv) begin
                    chk("sb_resp_data", Resp_Data, m_rdata);
                    chk("sb_resp_id", Resp_ID, m_id);
                    chk("sb_resp_err", Resp_Err, m_rerr);
                end
                chk("sb_enable", ALU_Enable, exp_en);
                if (exp_en) begin
                    chk("sb_alu_a", ALU_A, m_a);
                    chk("sb_alu_b", ALU_B, m_b);
                    chk("sb_alu_fun", ALU_FUN, m_fun);
                end
                if (!m_busy) begin
                    w = winner(Req0_Valid, Req1_Valid, m_last);
                    chk("sb_ready0", Req0_Ready, (w == 0));
                    chk("sb_ready1", Req1_Ready, (w == 1));
                    if (w >= 0) begin
                        m_busy = 1; m_gcyc = c; m_rcyc = -1; m_last = w; m_id = w;
                        m_a   = (w == 0) ? Req0_A : Req1_A;
                        m_b   = (w == 0) ? Req0_B : Req1_B;
                        m_fun = (w == 0) ? Req0_Fun : Req1_Fun;
                    end
                end else begin
                    chk("sb_ready0_busy", Req0_Ready, 0);
                    chk("sb_ready1_busy", Req1_Ready, 0);
                    if (m_rcyc < 0 && c >= m_gcyc + 2) begin
                        if (ALU_Out_Valid) begin
                            m_rcyc = c + 1; m_rdata = ref_alu(m_a, m_b, m_fun); m_rerr = 0;
                        end else if (c == m_gcyc + 1 + TO) begin
                            m_rcyc = c + 1; m_rdata = '0; m_rerr = 1;
                        end
                    end
                    if (exp_rv && Resp_Ready) m_busy = 0;
                end
            end
        end
    end

    // Present one command on requester 0; returns the grant cycle
    task automatic issue0(input logic [W-1:0] a, input logic [W-1:0] b, input logic [FW-1:0] f, output int g);
        @(posedge CLK); #1;
        Req0_Valid = 1'b1; Req0_A = a; Req0_B = b; Req0_Fun = f;
        @(negedge CLK);
        g = cyc;
        chk("issue0_ready", Req0_Ready, 1);
        @(posedge CLK); #1;
        Req0_Valid = 1'b0;
    endtask

    task automatic wait_resp(output int r);
        bit found;
        found = 0; r = -1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge CLK);
            if (Resp_Valid) begin found = 1; r = cyc; end
        end
        if (!found) chk("wait_resp_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int i = 0; i < 60 && !idle; i++) begin
            @(negedge CLK);
            if (!Busy) idle = 1;
        end
        if (!idle) chk("wait_idle_timeout", 0, 1);
    endtask

    initial begin
        int g, r, n_g, n_r;
        int gq[8];
        int rq[8];
        logic [W-1:0] a, b, d;
        logic [FW-1:0] f;

        RST = 1'b1;
        Req0_Valid = 0; Req0_A = '0; Req0_B = '0; Req0_Fun = '0;
        Req1_Valid = 0; Req1_A = '0; Req1_B = '0; Req1_Fun = '0;
        Resp_Ready = 1'b1;
        #3 RST = 1'b0;

        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_busy", Busy, 0);
        chk("rst_enable", ALU_Enable, 0);
        chk("rst_resp_valid", Resp_Valid, 0);
        chk("rst_resp_data", Resp_Data, 0);
        chk("rst_alu_a", ALU_A, 0);
        @(posedge CLK); #1 RST = 1'b1;

        // Single request: 3 + 4
        alu_lat = 1;
        issue0(16'h0003, 16'h0004, 4'b0000, g);
        @(negedge CLK);
        chk("single_enable", ALU_Enable, 1);
        chk("single_alu_a", ALU_A, 16'h0003);
        chk("single_alu_b", ALU_B, 16'h0004);
        wait_resp(r);
        chk("single_latency", r - g, 3);
        chk("single_data", Resp_Data, 16'h0007);
        chk("single_id", Resp_ID, 0);
        chk("single_err", Resp_Err, 0);
        wait_idle();

        // Timeout: ALU never answers
        alu_lat = 0;
        issue0(16'h1111, 16'h2222, 4'b0101, g);
        wait_resp(r);
        chk("to_latency", r - g, TO + 2);
        chk("to_err", Resp_Err, 1);
        chk("to_data", Resp_Data, 0);
        wait_idle();

        // Result in the final watchdog cycle wins over the timeout
        alu_lat = TO;
        issue0(16'h00F0, 16'h0F0F, 4'b0111, g);
        wait_resp(r);
        chk("late_latency", r - g, TO + 2);
        chk("late_err", Resp_Err, 0);
        chk("late_data", Resp_Data, 16'h0FFF);
        wait_idle();

        // Backpressure with spurious ALU pulses; requester 1 waits behind it
        alu_lat = 1; spur_en = 1; Resp_Ready = 1'b0;
        a = 16'h1234; b = 16'h0101; f = 4'b0001;
        issue0(a, b, f, g);
        Req1_Valid = 1'b1; Req1_A = 16'hAAAA; Req1_B = 16'h5555; Req1_Fun = 4'b0100;
        wait_resp(r);
        d = ref_alu(a, b, f);
        for (int i = 0; i < 5; i++) begin
            chk("bp_data_held", Resp_Data, d);
            chk("bp_id_held", Resp_ID, 0);
            chk("bp_req1_blocked", Req1_Ready, 0);
            if (i < 4) @(negedge CLK);
        end
        @(posedge CLK); #1 Resp_Ready = 1'b1;
        @(negedge CLK);
        chk("bp_valid_at_accept", Resp_Valid, 1);
        @(negedge CLK);
        chk("bp_req1_granted", Req1_Ready, 1);
        @(posedge CLK); #1 Req1_Valid = 1'b0;
        wait_idle();
        spur_en = 0;

        // Simultaneous requests after reset alternate 0,1,0,1
        @(posedge CLK); #1 RST = 1'b0;
        @(posedge CLK); #1 RST = 1'b1;
        Req0_Valid = 1'b1; Req0_A = 16'h0010; Req0_B = 16'h0001; Req0_Fun = 4'b0000;
        Req1_Valid = 1'b1; Req1_A = 16'h0020; Req1_B = 16'h0002; Req1_Fun = 4'b0001;
        n_g = 0; n_r = 0;
        for (int i = 0; i < 60 && n_r < 4; i++) begin
            @(negedge CLK);
            if (Req0_Ready && n_g < 8) begin gq[n_g] = 0; n_g++; end
            if (Req1_Ready && n_g < 8) begin gq[n_g] = 1; n_g++; end
            if (Resp_Valid && Resp_Ready && n_r < 8) begin rq[n_r] = Resp_ID; n_r++; end
        end
        @(posedge CLK); #1 Req0_Valid = 1'b0; Req1_Valid = 1'b0;
        chk("rr_resp_count", n_r, 4);
        if (n_g >= 4 && n_r >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("rr_grant_seq", gq[i], i % 2);
                chk("rr_resp_id_seq", rq[i], i % 2);
            end
        end else chk("rr_grant_count", n_g, 4);
        wait_idle();

        // Asynchronous reset while waiting on the ALU
        alu_lat = 0;
        issue0(16'h1234, 16'h5678, 4'b0110, g);
        Req0_Valid = 1'b1; Req1_Valid = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("areset_busy", Busy, 0);
        chk("areset_alu_a", ALU_A, 0);
        chk("areset_alu_b", ALU_B, 0);
        chk("areset_alu_fun", ALU_FUN, 0);
        chk("areset_enable", ALU_Enable, 0);
        chk("areset_resp_valid", Resp_Valid, 0);
        chk("areset_resp_data", Resp_Data, 0);
        chk("areset_resp_err", Resp_Err, 0);
        chk("areset_ready0", Req0_Ready, 0);
        chk("areset_ready1", Req1_Ready, 0);
        @(posedge CLK); #1 RST = 1'b1;
        @(negedge CLK);
        chk("areset_first_grant0", Req0_Ready, 1);
        chk("areset_first_grant1", Req1_Ready, 0);
        @(posedge CLK); #1 Req0_Valid = 1'b0; Req1_Valid = 1'b0;
        wait_idle();

        // Randomized traffic, latency, backpressure and spurious pulses
        spur_en = 1;
        for (int i = 0; i < 1500; i++) begin
            @(posedge CLK); #1;
            Req0_Valid = ($urandom_range(0, 2) == 0);
            Req1_Valid = ($urandom_range(0, 2) == 0);
            Req0_A = W'($urandom); Req0_B = W'($urandom); Req0_Fun = FW'($urandom);
            Req1_A = W'($urandom); Req1_B = W'($urandom); Req1_Fun = FW'($urandom);
            Resp_Ready = ($urandom_range(0, 3) != 0);
            alu_lat = $urandom_range(0, TO + 1);
        end
        @(posedge CLK); #1;
        Req0_Valid = 1'b0; Req1_Valid = 1'b0; Resp_Ready = 1'b1;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
